// File: rtl/a8_bus_sampler_if.sv
// Atari 8-bit bus pins in, qualified sysclk-domain bus events out.
interface a8_bus_sampler_if;
  logic        a8_clk;
  logic [15:0] a8_a_IN;
  logic [7:0]  a8_d_IN;
  logic        a8_rw_IN;
  logic        a8_halt_n_IN;
  logic        a8_ref_n_IN;

  logic        cyc_start;
  logic        addr_stb;
  logic [15:0] bus_addr;
  logic        bus_rw_n;
  logic        bus_dma;
  logic        bus_ref;
  logic        rd_stb;
  logic        wr_stb;
  logic [7:0]  wr_data;
  logic        cyc_err;
  logic        clk_lost;

  // master: the sampler (consumes pins, drives events); slave: downstream decode
  modport master (
    input  a8_clk, a8_a_IN, a8_d_IN, a8_rw_IN, a8_halt_n_IN, a8_ref_n_IN,
    output cyc_start, addr_stb, bus_addr, bus_rw_n, bus_dma, bus_ref,
           rd_stb, wr_stb, wr_data, cyc_err, clk_lost
  );
  modport slave (
    output a8_clk, a8_a_IN, a8_d_IN, a8_rw_IN, a8_halt_n_IN, a8_ref_n_IN,
    input  cyc_start, addr_stb, bus_addr, bus_rw_n, bus_dma, bus_ref,
           rd_stb, wr_stb, wr_data, cyc_err, clk_lost
  );
endinterface

// File: rtl/a8_bus_sampler.sv
// Synchronises phi2 into sysclk and captures address/R-W/write data at fixed
// sysclk taps after each detected cycle start, emitting single-cycle strobes.
module a8_bus_sampler #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned ADDR_TAP     = 18,
  parameter int unsigned WDATA_TAP    = 44,
  parameter int unsigned LOST_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 8
) (
  input  logic            sysclk,
  input  logic            sys_rst_n,
  a8_bus_sampler_if.master bus
);

  typedef enum logic [1:0] {IDLE, ADDR_WAIT, DATA_WAIT, HOLD} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   fall;

  logic        cyc_start_q, addr_stb_q, rd_stb_q, wr_stb_q, cyc_err_q, clk_lost_q;
  logic [15:0] bus_addr_q;
  logic [7:0]  wr_data_q;
  logic        bus_rw_n_q, bus_dma_q, bus_ref_q;

  assign fall = hist_q & ~sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d = cnt_q;
    if (fall)
      cnt_d = '0;
    else if (cnt_q != CNT_W'(LOST_TIMEOUT))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      hist_q      <= 1'b0;
      cnt_q       <= '0;
      cyc_start_q <= 1'b0;
      addr_stb_q  <= 1'b0;
      rd_stb_q    <= 1'b0;
      wr_stb_q    <= 1'b0;
      cyc_err_q   <= 1'b0;
      clk_lost_q  <= 1'b0;
      bus_addr_q  <= '0;
      wr_data_q   <= '0;
      bus_rw_n_q  <= 1'b1;
      bus_dma_q   <= 1'b0;
      bus_ref_q   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.a8_clk};
      hist_q      <= sync_q[SYNC_STAGES-1];
      cnt_q       <= cnt_d;
      cyc_start_q <= fall;
      addr_stb_q  <= 1'b0;
      rd_stb_q    <= 1'b0;
      wr_stb_q    <= 1'b0;
      cyc_err_q   <= 1'b0;

      // A new cycle start outranks both the timeout and any tap due this sysclk
      if (fall) begin
        clk_lost_q <= 1'b0;
        state_q    <= ADDR_WAIT;
        if (state_q == ADDR_WAIT || state_q == DATA_WAIT)
          cyc_err_q <= 1'b1;
      end else if (cnt_q == CNT_W'(LOST_TIMEOUT)) begin
        clk_lost_q <= 1'b1;
        state_q    <= IDLE;
      end else begin
        case (state_q)
          ADDR_WAIT: begin
            if (cnt_q == CNT_W'(ADDR_TAP)) begin
              bus_addr_q <= bus.a8_a_IN;
              bus_rw_n_q <= bus.a8_rw_IN;
              bus_dma_q  <= ~bus.a8_halt_n_IN;
              bus_ref_q  <= ~bus.a8_ref_n_IN;
              addr_stb_q <= 1'b1;
              rd_stb_q   <= bus.a8_rw_IN & bus.a8_ref_n_IN;
              state_q    <= (!bus.a8_rw_IN && bus.a8_ref_n_IN) ? DATA_WAIT : HOLD;
            end
          end
          DATA_WAIT: begin
            if (cnt_q == CNT_W'(WDATA_TAP)) begin
              wr_data_q <= bus.a8_d_IN;
              wr_stb_q  <= 1'b1;
              state_q   <= HOLD;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.cyc_start = cyc_start_q;
  assign bus.addr_stb  = addr_stb_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_rw_n  = bus_rw_n_q;
  assign bus.bus_dma   = bus_dma_q;
  assign bus.bus_ref   = bus_ref_q;
  assign bus.rd_stb    = rd_stb_q;
  assign bus.wr_stb    = wr_stb_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.cyc_err   = cyc_err_q;
  assign bus.clk_lost  = clk_lost_q;

endmodule

// File: tb/tb_a8_bus_sampler.sv
// Scoreboard bench: each driven a8 cycle queues its expected strobes, the
// negedge monitor pops and compares them as the sampler emits events.
module tb_a8_bus_sampler;

  localparam int unsigned ADDR_TAP  = 18;
  localparam int unsigned WDATA_TAP = 44;

  logic sysclk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sysclk = ~sysclk;

  a8_bus_sampler_if bus ();

  a8_bus_sampler #(
    .SYNC_STAGES (2),
    .ADDR_TAP    (ADDR_TAP),
    .WDATA_TAP   (WDATA_TAP),
    .LOST_TIMEOUT(255),
    .CNT_W       (8)
  ) dut (
    .sysclk   (sysclk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic        rw;
    logic        dma;
    logic        rf;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   err_cnt = 0;
  int   since_start = 1000;
  int   addr_at = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One Atari cycle starting at the phi2 falling edge; pins become valid at the
  // bus timing points and phi2 rises at 279ns.
  task automatic a8_cycle(input logic [15:0] addr, input logic [7:0] data,
                          input logic rw, input logic halt_n, input logic ref_n,
                          input int unsigned len_ns, input bit push_a, input bit push_w);
    exp_t e;
    bus.a8_clk       = 1'b0;
    bus.a8_a_IN      = 16'($urandom);
    bus.a8_d_IN      = 8'($urandom);
    bus.a8_rw_IN     = 1'($urandom);
    bus.a8_halt_n_IN = 1'($urandom);
    bus.a8_ref_n_IN  = 1'($urandom);
    e.addr = addr; e.rw = rw; e.dma = ~halt_n; e.rf = ~ref_n; e.data = data;
    if (push_a) begin e.is_wr = 1'b0; sb.push_back(e); end
    if (push_w) begin e.is_wr = 1'b1; sb.push_back(e); end
    #177;
    bus.a8_a_IN = addr; bus.a8_rw_IN = rw;
    bus.a8_halt_n_IN = halt_n; bus.a8_ref_n_IN = ref_n;
    #102;
    bus.a8_clk = 1'b1;
    if (len_ns > 422) begin
      #143;
      bus.a8_d_IN = data;
      #(len_ns - 422);
    end else begin
      #(len_ns - 279);
    end
  endtask

  task automatic cyc(input logic [15:0] addr, input logic [7:0] data,
                     input logic rw, input logic halt_n, input logic ref_n);
    a8_cycle(addr, data, rw, halt_n, ref_n, 558, 1'b1, !rw && ref_n);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stb"}, {bus.cyc_start, bus.addr_stb, bus.rd_stb, bus.wr_stb, bus.cyc_err}, '0);
    chk({tag, "_addr"}, bus.bus_addr, 16'h0000);
    chk({tag, "_wdata"}, bus.wr_data, 8'h00);
    chk({tag, "_flags"}, {bus.bus_rw_n, bus.bus_dma, bus.bus_ref, bus.clk_lost}, 4'b1000);
  endtask

  always @(negedge sysclk) begin
    if (sys_rst_n) begin
      exp_t e;
      since_start = bus.cyc_start ? 0 : since_start + 1;
      if (bus.cyc_err) err_cnt++;
      if (bus.rd_stb && !bus.addr_stb) chk("rd_without_addr", 1, 0);
      if (bus.addr_stb) begin
        chk("addr_dly", since_start, ADDR_TAP + 1);
        chk("addr_wr_excl", bus.wr_stb, 0);
        addr_at = since_start;
        if (sb.size() == 0) chk("unexpected_addr_stb", 1, 0);
        else begin
          e = sb.pop_front();
          chk("addr_kind", e.is_wr, 0);
          chk("bus_addr", bus.bus_addr, e.addr);
          chk("bus_rw_n", bus.bus_rw_n, e.rw);
          chk("bus_dma", bus.bus_dma, e.dma);
          chk("bus_ref", bus.bus_ref, e.rf);
          chk("rd_stb", bus.rd_stb, e.rw & ~e.rf);
        end
      end else if (bus.wr_stb) begin
        chk("wr_gap", since_start - addr_at, WDATA_TAP - ADDR_TAP);
        if (sb.size() == 0) chk("unexpected_wr_stb", 1, 0);
        else begin
          e = sb.pop_front();
          chk("wr_kind", e.is_wr, 1);
          chk("wr_data", bus.wr_data, e.data);
        end
      end
    end
  end

  initial begin
    bit found;
    bus.a8_clk = 1'b1; bus.a8_a_IN = '0; bus.a8_d_IN = '0;
    bus.a8_rw_IN = 1'b1; bus.a8_halt_n_IN = 1'b1; bus.a8_ref_n_IN = 1'b1;

    // Reset with phi2 running
    a8_cycle(16'h1111, 8'h11, 1'b0, 1'b1, 1'b1, 558, 1'b0, 1'b0);
    a8_cycle(16'h2222, 8'h22, 1'b1, 1'b1, 1'b1, 558, 1'b0, 1'b0);
    chk_reset_vals("rst1");
    @(negedge sysclk); sys_rst_n = 1'b1;
    @(negedge sysclk);
    chk("post_release_quiet", {bus.cyc_start, bus.addr_stb, bus.wr_stb, bus.cyc_err}, '0);
    cyc(16'h1234, 8'h00, 1'b1, 1'b1, 1'b1);

    // Write, read, refresh, DMA write
    cyc(16'hD604, 8'h05, 1'b0, 1'b1, 1'b1);
    cyc(16'h0607, 8'h00, 1'b1, 1'b1, 1'b1);
    cyc(16'h4000, 8'h00, 1'b1, 1'b1, 1'b0);
    cyc(16'h5A5A, 8'hC3, 1'b0, 1'b0, 1'b1);

    // Short write cycle aborted by an early phi2 fall, then a normal cycle
    a8_cycle(16'hD40A, 8'h77, 1'b0, 1'b1, 1'b1, 300, 1'b1, 1'b0);
    cyc(16'hBEEF, 8'h3C, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 6; i++)
      cyc(16'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom_range(3, 0) != 0));

    // Stopped phi2 then resume
    #3000;
    @(negedge sysclk);
    chk("clk_lost_set", bus.clk_lost, 1);
    fork
      cyc(16'hA5A5, 8'h00, 1'b1, 1'b1, 1'b1);
      begin
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
          @(negedge sysclk);
          if (bus.cyc_start) found = 1'b1;
        end
        chk("resume_cyc_start", found, 1);
        chk("clk_lost_clr", bus.clk_lost, 0);
      end
    join

    // Reset between address tap and write-data tap
    fork
      a8_cycle(16'hC0DE, 8'h99, 1'b0, 1'b1, 1'b1, 558, 1'b1, 1'b0);
      begin
        #330;
        sys_rst_n = 1'b0;
        #1;
        chk_reset_vals("rst7");
        #40;
        sys_rst_n = 1'b1;
      end
    join
    cyc(16'h0301, 8'h00, 1'b1, 1'b1, 1'b1);
    cyc(16'hD01F, 8'h08, 1'b0, 1'b1, 1'b1);
    #200;

    chk("sb_drained", sb.size(), 0);
    chk("cyc_err_count", err_cnt, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
